// File: rtl/exc_seq_if.sv
// exc_seq_if: bundles the controller request lines, the CP0 status/target
// inputs and the sequencer's CP0/fetch outputs into one port.
//   master : the controller/CP0 side, drives requests, status, exc_addr.
//   slave  : the sequencer, drives busy, CP0 pulses, redirect and counter.
interface exc_seq_if #(
    parameter int unsigned CNT_W = 8
);
    logic             valid;
    logic             syscall;
    logic             brk;
    logic             teq;
    logic             teq_eq;
    logic             eret_req;
    logic [31:0]      inst_pc;
    logic [31:0]      status;
    logic [31:0]      exc_addr;
    logic             busy;
    logic             exception;
    logic [4:0]       cause;
    logic [31:0]      epc;
    logic             eret;
    logic             pc_load;
    logic [31:0]      pc_target;
    logic [CNT_W-1:0] exc_count;

    modport master (
        output valid, syscall, brk, teq, teq_eq, eret_req, inst_pc, status, exc_addr,
        input  busy, exception, cause, epc, eret, pc_load, pc_target, exc_count
    );

    modport slave (
        input  valid, syscall, brk, teq, teq_eq, eret_req, inst_pc, status, exc_addr,
        output busy, exception, cause, epc, eret, pc_load, pc_target, exc_count
    );
endinterface

// File: rtl/exc_seq.sv
// exc_seq: exception sequencer in front of the CP0 register block.
// Decides whether a SYSCALL/BREAK/TEQ trap is taken (gated by Status),
// pulses CP0's exception/cause/epc, then redirects fetch to exc_addr.
// ERET pulses eret together with pc_load in a single cycle.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - exc_seq_if.slave: controller requests, CP0 status/exc_addr,
//          busy stall, CP0 pulses, fetch redirect, taken-exception count
module exc_seq #(
    parameter int unsigned CNT_W = 8
) (
    input  logic      clk,
    input  logic      rst,
    exc_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TAKE     = 2'd1,
        REDIRECT = 2'd2,
        RET      = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [4:0]       cause_q;
    logic [31:0]      epc_q;
    logic [CNT_W-1:0] cnt_q;

    logic             brk_ok, sys_ok, teq_ok;
    logic             exc_hit, ret_hit;
    logic [4:0]       cause_sel;
    logic             status_unused;

    // Only Status[3:0] carry enables for this block.
    assign status_unused = ^bus.status[31:4];

    // Request qualification; only meaningful while IDLE.
    always_comb begin
        brk_ok    = bus.brk     & bus.status[0] & bus.status[2];
        sys_ok    = bus.syscall & bus.status[0] & bus.status[1];
        teq_ok    = bus.teq & bus.teq_eq & bus.status[0] & bus.status[3];
        exc_hit   = bus.valid & (brk_ok | sys_ok | teq_ok);
        // An eligible exception always wins over ERET.
        ret_hit   = bus.valid & bus.eret_req & ~exc_hit;
        if (brk_ok)      cause_sel = 5'd9;
        else if (sys_ok) cause_sel = 5'd8;
        else             cause_sel = 5'd13;
    end

    // State register, latched cause/epc and saturating counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && exc_hit) begin
                cause_q <= cause_sel;
                epc_q   <= bus.inst_pc;
                if (cnt_q != '1)
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Next-state logic; requests are ignored outside IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (exc_hit)      state_nxt = TAKE;
                else if (ret_hit) state_nxt = RET;
            end
            TAKE:     state_nxt = REDIRECT;
            REDIRECT: state_nxt = IDLE;
            RET:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs. busy is gated by rst so every output reads 0 during reset,
    // including the combinational accept path.
    always_comb begin
        bus.busy      = 1'b0;
        bus.exception = 1'b0;
        bus.cause     = '0;
        bus.epc       = '0;
        bus.eret      = 1'b0;
        bus.pc_load   = 1'b0;
        bus.pc_target = '0;
        bus.exc_count = cnt_q;
        unique case (state)
            IDLE: begin
                bus.busy = rst & (exc_hit | ret_hit);
            end
            TAKE: begin
                bus.busy      = 1'b1;
                bus.exception = 1'b1;
                bus.cause     = cause_q;
                bus.epc       = epc_q;
            end
            REDIRECT: begin
                bus.busy      = 1'b1;
                bus.pc_load   = 1'b1;
                bus.pc_target = bus.exc_addr;
            end
            RET: begin
                bus.busy      = 1'b1;
                bus.eret      = 1'b1;
                bus.pc_load   = 1'b1;
                bus.pc_target = bus.exc_addr;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_exc_seq.sv
// tb_exc_seq: self-checking bench for exc_seq. Two instances (CNT_W=8 and
// CNT_W=2) see identical stimulus. A queue-based model schedules the
// expected output pulses for future cycles whenever a request is accepted.
module tb_exc_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v, sc, bk, tq, tqe, er;
    logic [31:0] ipc, st, ea;

    exc_seq_if #(.CNT_W(8)) bus8 ();
    exc_seq_if #(.CNT_W(2)) bus2 ();

    assign bus8.valid = v;   assign bus2.valid = v;
    assign bus8.syscall = sc; assign bus2.syscall = sc;
    assign bus8.brk = bk;    assign bus2.brk = bk;
    assign bus8.teq = tq;    assign bus2.teq = tq;
    assign bus8.teq_eq = tqe; assign bus2.teq_eq = tqe;
    assign bus8.eret_req = er; assign bus2.eret_req = er;
    assign bus8.inst_pc = ipc; assign bus2.inst_pc = ipc;
    assign bus8.status = st; assign bus2.status = st;
    assign bus8.exc_addr = ea; assign bus2.exc_addr = ea;

    exc_seq #(.CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    exc_seq #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    // ---------------- behavioural model ----------------
    typedef struct {
        logic        exc;
        logic [4:0]  cause;
        logic [31:0] epc;
        logic        eret;
        logic        pcl;
    } ev_t;

    ev_t         q[$];
    int unsigned taken;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    // ExcCode of the winning eligible trap, 0 when none.
    function automatic logic [4:0] pick();
        if (!st[0])                 return 5'd0;
        if (bk && st[2])            return 5'd9;
        if (sc && st[1])            return 5'd8;
        if (tq && tqe && st[3])     return 5'd13;
        return 5'd0;
    endfunction

    task automatic model_clock();
        logic [4:0] c;
        if (!rst) begin
            q.delete();
            taken = 0;
        end else if (q.size() != 0) begin
            void'(q.pop_front());
        end else if (v) begin
            c = pick();
            if (c != 5'd0) begin
                q.push_back('{1'b1, c, ipc, 1'b0, 1'b0});
                q.push_back('{1'b0, 5'd0, 32'd0, 1'b0, 1'b1});
                taken++;
            end else if (er) begin
                q.push_back('{1'b0, 5'd0, 32'd0, 1'b1, 1'b1});
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        ev_t  e;
        logic eb;
        e  = '{1'b0, 5'd0, 32'd0, 1'b0, 1'b0};
        if (q.size() != 0) e = q[0];
        eb = rst && (q.size() != 0 || (v && (pick() != 5'd0 || er)));
        chk("busy",      32'(bus8.busy),      32'(eb));
        chk("exception", 32'(bus8.exception), 32'(e.exc));
        chk("cause",     32'(bus8.cause),     32'(e.cause));
        chk("epc",       bus8.epc,            e.epc);
        chk("eret",      32'(bus8.eret),      32'(e.eret));
        chk("pc_load",   32'(bus8.pc_load),   32'(e.pcl));
        chk("pc_target", bus8.pc_target,      e.pcl ? ea : 32'd0);
        chk("exc_count8", 32'(bus8.exc_count), (taken > 255) ? 32'd255 : 32'(taken));
        chk("exc_count2", 32'(bus2.exc_count), (taken > 3) ? 32'd3 : 32'(taken));
    endtask

    task automatic obs();
        @(negedge clk);
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic clr_in();
        v = 0; sc = 0; bk = 0; tq = 0; tqe = 0; er = 0;
    endtask

    task automatic do_reset();
        clr_in();
        rst = 0;
        #1;
        model_clock();
        obs();
        chk("rst_busy",    32'(bus8.busy), 32'd0);
        chk("rst_count",   32'(bus8.exc_count), 32'd0);
        adv();
        rst = 1;
    endtask

    // Full syscall sequence with literal expectations; returns in IDLE.
    task automatic syscall_seq(input logic [31:0] pc);
        st = 32'h0000000F; ea = 32'h00400004;
        v = 1; sc = 1; ipc = pc;
        obs(); chk("acc_busy", 32'(bus8.busy), 32'd1); adv();
        clr_in();
        obs();
        chk("n1_exception", 32'(bus8.exception), 32'd1);
        chk("n1_cause",     32'(bus8.cause), 32'd8);
        chk("n1_epc",       bus8.epc, pc);
        adv();
        obs();
        chk("n2_pc_load",   32'(bus8.pc_load), 32'd1);
        chk("n2_pc_target", bus8.pc_target, 32'h00400004);
        adv();
        obs(); adv();
    endtask

    task automatic single_trap(input logic b, input logic s, input logic t,
                               input logic te, input logic [31:0] stat,
                               input logic [31:0] exp_cause, input string nm);
        st = stat; v = 1; bk = b; sc = s; tq = t; tqe = te; ipc = 32'h00400200;
        obs(); adv();
        clr_in();
        obs(); chk(nm, 32'(bus8.cause), exp_cause); adv();
        obs(); adv();
        obs(); adv();
    endtask

    int unsigned exp2[5] = '{1, 2, 3, 3, 3};

    initial begin
        clr_in();
        ipc = '0; st = '0; ea = '0;
        taken = 0;
        rst = 0;
        #1;
        model_clock();
        obs();
        chk("reset_busy",      32'(bus8.busy), 32'd0);
        chk("reset_exception", 32'(bus8.exception), 32'd0);
        chk("reset_pc_load",   32'(bus8.pc_load), 32'd0);
        chk("reset_count",     32'(bus8.exc_count), 32'd0);
        adv();
        rst = 1;
        obs(); adv();

        // Basic syscall
        syscall_seq(32'h00400100);
        chk("count_after_1", 32'(bus8.exc_count), 32'd1);

        // Masked requests: nothing happens
        st = 32'h0000000D; v = 1; sc = 1;
        obs(); chk("masked_sys_busy", 32'(bus8.busy), 32'd0); adv();
        obs(); chk("masked_sys_exc", 32'(bus8.exception), 32'd0); adv();
        clr_in();
        st = 32'h0000000E; v = 1; bk = 1;
        obs(); chk("masked_brk_busy", 32'(bus8.busy), 32'd0); adv();
        obs(); chk("masked_brk_exc", 32'(bus8.exception), 32'd0); adv();
        clr_in();
        chk("count_unchanged", 32'(bus8.exc_count), 32'd1);

        // Priority and TEQ
        single_trap(1, 1, 1, 1, 32'h0000000F, 32'd9, "prio_cause");
        st = 32'h0000000F; v = 1; tq = 1; tqe = 0;
        obs(); chk("teq_false_busy", 32'(bus8.busy), 32'd0); adv();
        obs(); chk("teq_false_exc", 32'(bus8.exception), 32'd0); adv();
        clr_in();
        single_trap(0, 0, 1, 1, 32'h0000000F, 32'd13, "teq_cause");

        // ERET
        ea = 32'h00400104; v = 1; er = 1;
        obs(); adv();
        clr_in();
        obs();
        chk("ret_eret",      32'(bus8.eret), 32'd1);
        chk("ret_pc_load",   32'(bus8.pc_load), 32'd1);
        chk("ret_pc_target", bus8.pc_target, 32'h00400104);
        adv();
        obs(); chk("ret_idle_busy", 32'(bus8.busy), 32'd0); adv();

        // ERET + enabled syscall -> exception path
        v = 1; er = 1; sc = 1;
        obs(); adv();
        clr_in();
        obs();
        chk("eret_vs_sys_exc",  32'(bus8.exception), 32'd1);
        chk("eret_vs_sys_eret", 32'(bus8.eret), 32'd0);
        adv();
        obs(); adv();

        // Reset during REDIRECT
        ea = 32'h00400004; v = 1; sc = 1; ipc = 32'h00400300;
        obs(); adv();
        clr_in();
        obs(); adv();
        #2;
        chk("redir_pc_load", 32'(bus8.pc_load), 32'd1);
        rst = 0;
        #1;
        chk("abort_pc_load",   32'(bus8.pc_load), 32'd0);
        chk("abort_pc_target", bus8.pc_target, 32'd0);
        chk("abort_count",     32'(bus8.exc_count), 32'd0);
        model_clock();
        obs(); adv();
        rst = 1;
        obs(); adv();
        syscall_seq(32'h00400400);

        // Saturation on the 2-bit counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            syscall_seq(32'h00401000 + 32'(i * 4));
            chk("sat_count2", 32'(bus2.exc_count), 32'(exp2[i]));
        end

        // Randomized stimulus
        for (int i = 0; i < 3000; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            sc  = 1'($urandom_range(0, 1));
            bk  = ($urandom_range(0, 3) == 0);
            tq  = 1'($urandom_range(0, 1));
            tqe = 1'($urandom_range(0, 1));
            er  = ($urandom_range(0, 2) == 0);
            st  = {$urandom_range(0, 15) == 0 ? 28'hFFFFFFF : 28'h0,
                   4'($urandom_range(0, 15)) | ($urandom_range(0, 3) != 0 ? 4'h1 : 4'h0)};
            ipc = $urandom();
            ea  = $urandom();
            if ($urandom_range(0, 249) == 0) begin
                #2;
                rst = 0;
                #1;
                model_clock();
                obs(); adv();
                rst = 1;
            end else begin
                obs(); adv();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/exc_seq.md
# exc_seq

Exception sequencer for the multi-cycle 54-instruction MIPS core. It sits directly upstream of the CP0 register block. It takes decoded trap/return requests from the controller and the current Status word from CP0. It decides whether an exception is taken, drives CP0's `exception`/`cause`/`pc`/`eret` inputs with one-cycle pulses, then issues a PC redirect to the fetch stage using CP0's `exc_addr`.

## Interface
Parameters:
- `CNT_W`, 8, width of the saturating taken-exception counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `valid`  in  1  controller presents a decoded instruction this cycle.
- `syscall`  in  1  instruction is SYSCALL.
- `brk`  in  1  instruction is BREAK.
- `teq`  in  1  instruction is TEQ.
- `teq_eq`  in  1  rs == rt for TEQ.
- `eret_req`  in  1  instruction is ERET.
- `inst_pc`  in  32  PC of the presented instruction.
- `status`  in  32  CP0 Status (reg 12).
- `exc_addr`  in  32  CP0 exception/return target.
- `busy`  out  1  controller must hold its state and inputs while high.
- `exception`  out  1  one-cycle pulse to CP0.
- `cause`  out  5  ExcCode to CP0.
- `epc`  out  32  PC to CP0.
- `eret`  out  1  one-cycle pulse to CP0.
- `pc_load`  out  1  one-cycle pulse; fetch loads `pc_target`.
- `pc_target`  out  32  redirect address.
- `exc_count`  out  CNT_W  number of taken exceptions, saturating.

## Operation
- Status bit usage:
  - bit0 = global enable.
  - bit1 = SYSCALL enable.
  - bit2 = BREAK enable.
  - bit3 = TEQ enable.
- A request is eligible only if bit0 and its own enable bit are set.
- CP0's shift-left-by-5 on entry clears these bits, which masks nested exceptions until ERET.
- Trap conditions and ExcCodes:
  - SYSCALL: `syscall`, cause 5'd8.
  - BREAK: `brk`, cause 5'd9.
  - TEQ: `teq & teq_eq`, cause 5'd13.
- Priority when several are asserted: BREAK > SYSCALL > TEQ. An eligible exception beats `eret_req`.
- A masked or false trap (e.g. TEQ with `teq_eq`=0) produces no action: state stays IDLE and `busy` stays 0.
- FSM states and transitions:
  - IDLE:
    - on `valid` with an eligible exception, latch cause and `inst_pc` and go to TAKE.
    - else on `valid & eret_req`, go to RET.
  - TAKE: `exception`=1, `cause`/`epc` = latched values. Next state is REDIRECT.
  - REDIRECT: `pc_load`=1, `pc_target`=`exc_addr` (CP0 supplies 32'h00400004 when `eret`=0). Next state is IDLE.
  - RET: `eret`=1 and `pc_load`=1 in the same cycle; `pc_target`=`exc_addr` (CP0 supplies EPC+4 when `eret`=1). Next state is IDLE.
- `busy` = (state != IDLE) | (IDLE & `valid` & action accepted). It is combinational so the controller stalls in the accepting cycle.
- Inputs are ignored outside IDLE.
- `exc_count` increments on entry to TAKE and saturates at all-ones.
- `cause`/`epc` read 0 whenever state != TAKE.
- `pc_target` reads 0 whenever `pc_load` = 0.

## Timing
- Reset (`rst`=0, asynchronous):
  - state = IDLE.
  - `exc_count`, latched cause, latched epc = 0.
  - All outputs 0: `busy`, `exception`, `cause`, `epc`, `eret`, `pc_load`, `pc_target`, `exc_count`.
- Reset mid-sequence (in TAKE, REDIRECT or RET) aborts immediately; no pulse is completed after release.
- Exception request sampled in cycle N:
  - TAKE in N+1; CP0 commits at the end of N+1.
  - REDIRECT in N+2.
  - IDLE in N+3, when a new `valid` may be accepted.
- ERET sampled in cycle N: RET in N+1, IDLE in N+2.
- `exception`, `eret` and `pc_load` are each exactly one cycle wide and never overlap except `eret`+`pc_load` in RET.
- Back-to-back: a second request presented in N+1 or N+2 is ignored. The controller re-presents it in IDLE, where it is then masked if CP0 Status was shifted.

## Test plan
- Reset, then `status`=32'h0000000F, `valid`+`syscall`, `inst_pc`=32'h00400100:
  - N+1: `exception`=1, `cause`=8, `epc`=32'h00400100.
  - N+2: `pc_load`=1, `pc_target`=32'h00400004.
  - `exc_count`=1.
- `status`=32'h0000000D (SYSCALL disabled), `valid`+`syscall` -> no pulses, `busy`=0, `exc_count` unchanged. Repeat with `status` bit0=0 and `brk` -> no action.
- `valid`+`brk`+`syscall`+`teq`+`teq_eq`, all enabled -> `cause`=9. Then TEQ with `teq_eq`=0 -> no action; with `teq_eq`=1 -> `cause`=13.
- `valid`+`eret_req`, `exc_addr`=32'h00400104 -> N+1: `eret`=1, `pc_load`=1, `pc_target`=32'h00400104; IDLE at N+2. `eret_req`+`syscall` enabled -> exception path taken, no `eret`.
- Assert `rst`=0 during REDIRECT -> `pc_load` drops asynchronously; all outputs 0; after release a fresh SYSCALL follows the normal N+1/N+2 sequence.
- With `CNT_W`=2, take 5 exceptions -> `exc_count` reads 1, 2, 3, 3, 3.
